booth16_iter_core: RTL and testbench
====================================

// Module: booth16_iter_core
// PURPOSE
//  Iterative signed radix-16 Booth multiplier core; consumes the multiplicand register output directly downstream of it.
//  Accepts a multiplier via valid/ready, pulses mcand_load to capture the multiplicand into the register,
//  precomputes odd multiples (3M,5M,7M), then retires one radix-16 digit per cycle, MSB digit first.
//  Delivers a 2*WIDTH signed product via valid/ready to the result/output stage.
// PARAMETERS
//  WIDTH  8  operand width, two's complement; NDIG = ceil(WIDTH/4) radix-16 digits (2 at default)
// PORTS
//  clk         in   1        single clock, all logic on rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        multiplier (and multiplicand at register input) valid
//  in_ready    out  1        core idle, will accept
//  multiplier  in   WIDTH    signed multiplier, latched on accept
//  mcand_load  out  1        load strobe to multiplicand register = in_valid & in_ready
//  mcand       in   WIDTH    signed multiplicand from multiplicand register dout
//  out_valid   out  1        product valid
//  out_ready   in   1        consumer accepts product
//  product     out  2*WIDTH  signed product
// BEHAVIOUR
//  Reset (rst=1 at an edge): state IDLE, acc/odd-multiple regs/product=0, out_valid=0.
//  Reset outputs: in_ready=1 (decoded from IDLE), mcand_load=0 while rst=1.
//  FSM: IDLE -> PRE3 -> PRE5 -> PRE7 -> ACC (NDIG cycles, digit counter NDIG-1 down to 0) -> DONE -> IDLE.
//  IDLE: in_ready=1; on in_valid: latch multiplier sign-extended to 4*NDIG bits with a 0 appended at LSB
//   (y[-1]=0); mcand_load=1 that cycle; acc<=0; go PRE3. mcand is read only from PRE3 on (register updated).
//  PRE3: m3<=M+2M; PRE5: m5<=M+4M; PRE7: m7<=8M-M. One shared adder, MW=WIDTH+4 signed.
//  ACC digit i: d = -8*y[4i+3]+4*y[4i+2]+2*y[4i+1]+y[4i]+y[4i-1], range -8..+8.
//   pp = sign(d)*|d|M; |d| in {0,1,2,4,8}=shifts of M, {3,5,7}=m3/m5/m7, 6=m3<<1.
//   Negation = two's complement of the selected magnitude.
//  acc <= (acc <<< 4) + sext(pp); acc width 4*NDIG+WIDTH+4 signed, no overflow possible.
//  Last ACC cycle: product <= acc_next[2*WIDTH-1:0] (exact for all inputs, incl. -2^(W-1) squared).
//  DONE: out_valid=1, product stable; out_valid&out_ready -> IDLE next cycle. No overlap: in_ready=0 in DONE.
//  Latency: accept at cycle 0 -> out_valid at cycle 4+NDIG (6 @ WIDTH=8).
//   Throughput with out_ready=1: one op per 5+NDIG cycles.
//  in_valid while not IDLE: ignored, no mcand_load. mcand must not change between PRE3 and DONE
//   (guaranteed: load strobe only in IDLE).
//  Backpressure: DONE holds indefinitely; product/out_valid constant until out_ready.
//  Reset mid-operation (any state): abort, next cycle IDLE, out_valid=0, product=0; no partial result emitted.
// STRUCTURE
//  booth16_pkg: state_t enum {IDLE,PRE3,PRE5,PRE7,ACC,DONE}; typedef logic signed [4:0] booth_digit_t;
//   function booth16_digit(input logic [4:0] win) -> booth_digit_t.
//  Sub-module booth16_pp_sel (combinational): window + M,m3,m5,m7 -> signed pp (MW bits).
//   FSM, counter, adder and accumulator stay in core.
// TESTING (WIDTH=8, latency/throughput checked by scoreboard)
//  mcand=3, mult=5, out_ready=1 -> product=15, out_valid exactly 6 cycles after accept, 1 cycle pulse.
//  mcand=3, mult=0x77 (digits 7,7) -> 357; mcand=-3, mult=0x78 (digits +8,-8) -> -360.
//  mcand=7, mult=0x35 (digits 3,5) -> 371.
//  Extremes: -128*-128 -> 16384; -128*127 -> -16256; 0*-1 -> 0; -1*-1 -> 1.
//  Backpressure: out_ready=0 for 10 cycles, in_valid pulsed -> product/out_valid held, in_ready=0, mcand_load=0.
//   Release -> IDLE next cycle.
//  rst=1 for 1 cycle during ACC -> next cycle IDLE, in_ready=1, out_valid=0; following op 9*-9 -> -81.
//  1000 random back-to-back ops, out_ready random -> all match a*b, no drops/duplicates, period 7 cycles when ready.

Source files
------------

// File: rtl/booth16_pkg.sv
// Shared types and the radix-16 Booth digit recoder for the iterative multiplier.
package booth16_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE3 = 3'd1,
    PRE5 = 3'd2,
    PRE7 = 3'd3,
    ACC  = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef logic signed [4:0] booth_digit_t;

  localparam int DIG_BITS = 4;

  // Window {y[4i+3], y[4i+2], y[4i+1], y[4i], y[4i-1]} -> digit in -8..+8.
  function automatic booth_digit_t booth16_digit(input logic [4:0] win);
    logic signed [5:0] w_hi;
    logic signed [5:0] w_lo;
    logic signed [5:0] w_sum;
    w_hi  = $signed({{2{win[4]}}, win[4:1]});
    w_lo  = $signed({5'b00000, win[0]});
    w_sum = w_hi + w_lo;
    return w_sum[4:0];
  endfunction

endpackage

// File: rtl/booth16_pp_sel.sv
// Partial-product selector: one Booth window plus precomputed multiples -> signed digit*M.
module booth16_pp_sel #(
  parameter int MW = 12
) (
  input  logic        [4:0]    i_win,
  input  logic signed [MW-1:0] i_m,
  input  logic signed [MW-1:0] i_m3,
  input  logic signed [MW-1:0] i_m5,
  input  logic signed [MW-1:0] i_m7,
  output logic signed [MW-1:0] o_pp
);
  import booth16_pkg::*;

  booth_digit_t        w_digit;
  logic                w_neg;
  logic        [4:0]   w_mag;
  logic signed [MW-1:0] w_sel;

  // Magnitude selection from shifts / odd multiples, then conditional negation.
  always_comb begin
    w_digit = booth16_digit(i_win);
    w_neg   = w_digit[4];
    w_mag   = w_neg ? -w_digit : w_digit;
    case (w_mag)
      5'd0:    w_sel = '0;
      5'd1:    w_sel = i_m;
      5'd2:    w_sel = i_m <<< 1;
      5'd3:    w_sel = i_m3;
      5'd4:    w_sel = i_m <<< 2;
      5'd5:    w_sel = i_m5;
      5'd6:    w_sel = i_m3 <<< 1;
      5'd7:    w_sel = i_m7;
      5'd8:    w_sel = i_m <<< 3;
      default: w_sel = '0;
    endcase
    if (w_neg) begin
      o_pp = -w_sel;
    end else begin
      o_pp = w_sel;
    end
  end

endmodule

// File: rtl/booth16_iter_core.sv
// Iterative signed radix-16 Booth multiplier: precompute 3M/5M/7M with one adder,
// then retire one digit per cycle, most significant digit first.
module booth16_iter_core #(
  parameter int WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic        [WIDTH-1:0]   i_multiplier,
  output logic                      o_mcand_load,
  input  logic        [WIDTH-1:0]   i_mcand,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [2*WIDTH-1:0] o_product
);
  import booth16_pkg::*;

  localparam int NDIG = (WIDTH + 3) / 4;
  localparam int YE   = 4 * NDIG;
  localparam int YW   = YE + 1;
  localparam int MW   = WIDTH + 4;
  localparam int AW   = YE + WIDTH + 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic        [YW-1:0]      r_y;
  logic signed [MW-1:0]      r_m3;
  logic signed [MW-1:0]      r_m5;
  logic signed [MW-1:0]      r_m7;
  logic signed [AW-1:0]      r_acc;
  logic        [CW-1:0]      r_cnt;
  logic signed [2*WIDTH-1:0] r_product;

  logic signed [MW-1:0]      w_m;
  logic signed [MW-1:0]      w_add_a;
  logic signed [MW-1:0]      w_add_b;
  logic signed [MW-1:0]      w_add_sum;
  logic                      w_add_sub;
  logic signed [MW-1:0]      w_pp;
  logic signed [AW-1:0]      w_acc_next;
  logic signed [YE-1:0]      w_mult_ext;
  logic        [4:0]         w_win;

  assign w_m          = MW'($signed(i_mcand));
  assign w_mult_ext   = YE'($signed(i_multiplier));
  assign o_in_ready   = (r_state == IDLE);
  assign o_mcand_load = i_in_valid & (r_state == IDLE) & ~i_rst;
  assign o_out_valid  = (r_state == DONE);
  assign o_product    = r_product;
  // The multiplier shifts left each digit, so the current window is always on top.
  assign w_win        = r_y[YW-1 -: 5];
  assign w_acc_next   = (r_acc <<< DIG_BITS) + AW'(w_pp);

  booth16_pp_sel #(.MW(MW)) u_pp_sel (
    .i_win (w_win),
    .i_m   (w_m),
    .i_m3  (r_m3),
    .i_m5  (r_m5),
    .i_m7  (r_m7),
    .o_pp  (w_pp)
  );

  // Shared adder operand steering for the odd-multiple precompute.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_sub = 1'b0;
    case (r_state)
      PRE3: begin
        w_add_a = w_m;
        w_add_b = w_m <<< 1;
      end
      PRE5: begin
        w_add_a = w_m;
        w_add_b = w_m <<< 2;
      end
      PRE7: begin
        w_add_a   = w_m <<< 3;
        w_add_b   = w_m;
        w_add_sub = 1'b1;
      end
      default: begin
        w_add_sub = 1'b0;
      end
    endcase
    w_add_sum = w_add_sub ? (w_add_a - w_add_b) : (w_add_a + w_add_b);
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_state_next = PRE3;
        end else begin
          w_state_next = IDLE;
        end
      end
      PRE3: w_state_next = PRE5;
      PRE5: w_state_next = PRE7;
      PRE7: w_state_next = ACC;
      ACC: begin
        if (r_cnt == '0) begin
          w_state_next = DONE;
        end else begin
          w_state_next = ACC;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: operand capture, odd multiples, digit accumulation, product hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y       <= '0;
      r_m3      <= '0;
      r_m5      <= '0;
      r_m7      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_y   <= {w_mult_ext, 1'b0};
            r_acc <= '0;
            r_cnt <= LAST_DIG;
          end
        end
        PRE3: r_m3 <= w_add_sum;
        PRE5: r_m5 <= w_add_sum;
        PRE7: r_m7 <= w_add_sum;
        ACC: begin
          r_acc <= w_acc_next;
          r_y   <= r_y << DIG_BITS;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_product <= w_acc_next[2*WIDTH-1:0];
          end
        end
        default: begin
          r_product <= r_product;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth16_iter_core.sv
// Self-checking bench for booth16_iter_core: directed corner cases, backpressure,
// mid-operation reset and randomized back-to-back traffic against plain a*b.
module tb_booth16_iter_core;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic        [7:0]  multiplier;
  logic               mcand_load;
  logic        [7:0]  mcand_d;
  logic        [7:0]  mcand_q;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] product;

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Multiplicand register feeding the core, loaded by its strobe.
  always @(posedge clk) begin
    if (mcand_load) mcand_q <= mcand_d;
  end

  booth16_iter_core #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_multiplier (multiplier),
    .o_mcand_load (mcand_load),
    .i_mcand      (mcand_q),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_product    (product)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the core idle; returns one negedge after the accept edge.
  task automatic start_op(input int a, input int b);
    mcand_d    = 8'(a);
    multiplier = 8'(b);
    in_valid   = 1'b1;
    #1;
    check("accept_ready", in_ready, 1);
    check("load_strobe", mcand_load, 1);
    @(negedge clk);
    in_valid   = 1'b0;
    mcand_d    = 8'($urandom);
    multiplier = 8'($urandom);
  endtask

  task automatic wait_result(input int exp, input bit noise);
    int n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      if (noise) begin
        in_valid   = 1'($urandom_range(0, 1));
        mcand_d    = 8'($urandom);
        multiplier = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check("latency", n, 6);
    check("product", product, exp);
  endtask

  task automatic drain(input int exp, input bit rand_ready);
    int stall = 0;
    bit rdy;
    do begin
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall >= 8) rdy = 1'b1;
      out_ready = rdy;
      if (rand_ready) begin
        in_valid   = 1'($urandom_range(0, 1));
        mcand_d    = 8'($urandom);
        multiplier = 8'($urandom);
      end
      @(negedge clk);
      if (!rdy) begin
        stall++;
        check("hold_valid", out_valid, 1);
        check("hold_product", product, exp);
        check("busy_load", mcand_load, 0);
      end
    end while (!rdy);
    in_valid = 1'b0;
    check("release_ready", in_ready, 1);
    check("release_valid", out_valid, 0);
  endtask

  initial begin
    int a;
    int b;
    int dir_a [8] = '{3, 3, -3, 7, -128, -128, 0, -1};
    int dir_b [8] = '{5, 119, 120, 53, -128, 127, -1, -1};
    int dir_p [8] = '{15, 357, -360, 371, 16384, -16256, 0, 1};

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    mcand_d    = 8'd0;
    multiplier = 8'd0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_load", mcand_load, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed values with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_op(dir_a[i], dir_b[i]);
      wait_result(dir_p[i], 1'b0);
      drain(dir_p[i], 1'b0);
    end

    // Backpressure: result must hold and new requests must be refused.
    out_ready = 1'b0;
    start_op(25, -4);
    wait_result(-100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'(i % 2);
      multiplier = 8'($urandom);
      mcand_d    = 8'($urandom);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_product", product, -100);
      check("bp_in_ready", in_ready, 0);
      check("bp_load", mcand_load, 0);
    end
    in_valid = 1'b0;
    check("bp_mcand_reg", mcand_q, 25);
    drain(-100, 1'b0);

    // Reset in the first accumulate cycle aborts the operation.
    out_ready = 1'b1;
    start_op(11, 13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_emit", out_valid, 0);
    end
    start_op(9, -9);
    wait_result(-81, 1'b0);
    drain(-81, 1'b0);

    // Random back-to-back traffic with random consumer stalls.
    for (int k = 0; k < 1000; k++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      start_op(a, b);
      wait_result(a * b, 1'b1);
      drain(a * b, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
